// File: rtl/i2c_sda_ctrl.sv
// Open-drain SDA shifter for the I2C master: START, byte write/read, ACK phase, STOP.
// Optional macro I2C_SDA_SYNC_EN puts sda_in through a 2-flop synchronizer before sampling.
`timescale 1ns/1ps
module i2c_sda_ctrl #(
    parameter int DATA_LEN   = 8,
    parameter int STOP_SETUP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    input  logic                sda_in,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    input  logic [DATA_LEN-1:0] tx_data,
    input  logic                mst_ack,
    output logic                cmd_ready,
    output logic                sda_oe,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                ack_rcvd,
    output logic                byte_done,
    output logic                stop_done,
    output logic                cmd_err,
    output logic                busy
);

    // state      | meaning
    // S_IDLE     | bus free, waiting for START
    // S_START    | SDA pulled low under high SCL, waiting for SCL fall
    // S_HOLD     | SCL low between phases, waiting for next command
    // S_DATA     | shifting DATA_LEN bits out (WRITE) or in (READ)
    // S_ACK      | ninth clock: slave ACK (WRITE) or master ACK/NACK (READ)
    // S_STOP     | SDA held low, waiting for SCL rise
    // S_STOP_WAIT| STOP setup time before SDA release
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_HOLD, S_DATA, S_ACK, S_STOP, S_STOP_WAIT
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    localparam int CNT_W  = (DATA_LEN > 2) ? $clog2(DATA_LEN) : 1;
    localparam int WAIT_W = (STOP_SETUP > 2) ? $clog2(STOP_SETUP) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(STOP_SETUP - 1);

    state_t              state, state_nxt;
    logic                scl_q, run;
    logic                sda_s;
    logic                sda_oe_nxt;
    logic [DATA_LEN-1:0] shreg, shreg_nxt;
    logic [DATA_LEN-1:0] rx_data_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                is_read, is_read_nxt;
    logic                mst_ack_l, mst_ack_l_nxt;
    logic                ack_rcvd_nxt;
    logic                byte_done_nxt, stop_done_nxt, cmd_err_nxt;
    logic                scl_rise, scl_fall, cmd_acc;

`ifdef I2C_SDA_SYNC_EN
    logic [1:0] sda_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sda_sync <= 2'b11;
        else        sda_sync <= {sda_sync[0], sda_in};
    end

    assign sda_s = sda_sync[1];
`else
    assign sda_s = sda_in;
`endif

    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    // run keeps cmd_ready low while reset is asserted
    assign cmd_ready = run & ((state == S_IDLE) | ((state == S_HOLD) & ~scl_q));
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            scl_q     <= 1'b1;
            run       <= 1'b0;
            sda_oe    <= 1'b0;
            shreg     <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            is_read   <= 1'b0;
            mst_ack_l <= 1'b0;
            ack_rcvd  <= 1'b0;
            byte_done <= 1'b0;
            stop_done <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            scl_q     <= scl;
            run       <= 1'b1;
            sda_oe    <= sda_oe_nxt;
            shreg     <= shreg_nxt;
            rx_data   <= rx_data_nxt;
            bit_cnt   <= bit_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            is_read   <= is_read_nxt;
            mst_ack_l <= mst_ack_l_nxt;
            ack_rcvd  <= ack_rcvd_nxt;
            byte_done <= byte_done_nxt;
            stop_done <= stop_done_nxt;
            cmd_err   <= cmd_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sda_oe_nxt    = sda_oe;
        shreg_nxt     = shreg;
        rx_data_nxt   = rx_data;
        bit_cnt_nxt   = bit_cnt;
        wait_cnt_nxt  = wait_cnt;
        is_read_nxt   = is_read;
        mst_ack_l_nxt = mst_ack_l;
        ack_rcvd_nxt  = ack_rcvd;
        byte_done_nxt = 1'b0;
        stop_done_nxt = 1'b0;
        cmd_err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (cmd == CMD_START) begin
                        sda_oe_nxt = 1'b1;
                        state_nxt  = S_START;
                    end else begin
                        cmd_err_nxt = 1'b1;
                    end
                end
            end
            S_START: begin
                if (scl_fall) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (cmd_acc) begin
                    case (cmd)
                        CMD_WRITE: begin
                            shreg_nxt   = tx_data;
                            sda_oe_nxt  = ~tx_data[DATA_LEN-1];
                            bit_cnt_nxt = BIT_LAST;
                            is_read_nxt = 1'b0;
                            state_nxt   = S_DATA;
                        end
                        CMD_READ: begin
                            sda_oe_nxt    = 1'b0;
                            bit_cnt_nxt   = BIT_LAST;
                            is_read_nxt   = 1'b1;
                            mst_ack_l_nxt = mst_ack;
                            state_nxt     = S_DATA;
                        end
                        CMD_STOP: begin
                            sda_oe_nxt = 1'b1;
                            state_nxt  = S_STOP;
                        end
                        default: cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            S_DATA: begin
                if (is_read && scl_rise) shreg_nxt = {shreg[DATA_LEN-2:0], sda_s};
                if (scl_fall) begin
                    if (bit_cnt == '0) begin
                        sda_oe_nxt = is_read ? mst_ack_l : 1'b0;
                        state_nxt  = S_ACK;
                    end else begin
                        bit_cnt_nxt = bit_cnt - CNT_W'(1);
                        if (!is_read) begin
                            shreg_nxt  = {shreg[DATA_LEN-2:0], 1'b0};
                            sda_oe_nxt = ~shreg[DATA_LEN-2];
                        end
                    end
                end
            end
            S_ACK: begin
                if (!is_read && scl_rise) ack_rcvd_nxt = ~sda_s;
                if (scl_fall) begin
                    sda_oe_nxt    = 1'b0;
                    byte_done_nxt = 1'b1;
                    if (is_read) rx_data_nxt = shreg;
                    state_nxt     = S_HOLD;
                end
            end
            S_STOP: begin
                if (scl_rise) begin
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = S_STOP_WAIT;
                end
            end
            S_STOP_WAIT: begin
                // SCL must stay high until SDA is released; a fall aborts the STOP
                if (scl_fall) begin
                    sda_oe_nxt  = 1'b0;
                    cmd_err_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else if (wait_cnt == '0) begin
                    sda_oe_nxt    = 1'b0;
                    stop_done_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_sda_ctrl.sv
// Directed bench for i2c_sda_ctrl: SCL and the slave are driven by hand, byte phases come from a vector table.
`timescale 1ns/1ps
module tb_i2c_sda_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_in;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       mst_ack;
    logic       cmd_ready;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       ack_rcvd;
    logic       byte_done;
    logic       stop_done;
    logic       cmd_err;
    logic       busy;
    logic       slave_low;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign sda_in = ~(sda_oe | slave_low);

    i2c_sda_ctrl #(.DATA_LEN(8), .STOP_SETUP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda_in    (sda_in),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .mst_ack   (mst_ack),
        .cmd_ready (cmd_ready),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .ack_rcvd  (ack_rcvd),
        .byte_done (byte_done),
        .stop_done (stop_done),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        logic       ack_in;      // WRITE: slave pulls SDA low in ACK; READ: mst_ack
        logic [7:0] exp_oe;      // expected sda_oe per data bit, MSB first
        logic [7:0] exp_rx;
        logic       exp_ackr;
        logic       exp_ack_oe;  // expected sda_oe through the ninth clock
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic scl_pulse();
        scl = 1'b1;
        step(4);
        scl = 1'b0;
        step(4);
    endtask

    // From IDLE with SCL high to HOLD with SCL low
    task automatic start_cond();
        issue(2'b00);
        chk("start_oe", int'(sda_oe), 1);
        chk("start_busy", int'(busy), 1);
        step(2);
        scl = 1'b0;
        step(4);
    endtask

    task automatic run_byte(input vec_t v, input int idx);
        tx_data = v.data;
        mst_ack = v.ack_in;
        issue(v.is_rd ? 2'b10 : 2'b01);
        step(2);
        for (int i = 7; i >= 0; i--) begin
            slave_low = v.is_rd ? ~v.data[i] : 1'b0;
            chk($sformatf("v%0d_bit%0d_oe", idx, i), int'(sda_oe), int'(v.exp_oe[i]));
            scl_pulse();
        end
        slave_low = v.is_rd ? 1'b0 : v.ack_in;
        chk($sformatf("v%0d_ack_low_oe", idx), int'(sda_oe), int'(v.exp_ack_oe));
        scl = 1'b1;
        step(4);
        chk($sformatf("v%0d_ack_high_oe", idx), int'(sda_oe), int'(v.exp_ack_oe));
        chk($sformatf("v%0d_no_early_done", idx), int'(byte_done), 0);
        scl = 1'b0;
        step();
        chk($sformatf("v%0d_byte_done", idx), int'(byte_done), 1);
        chk($sformatf("v%0d_released", idx), int'(sda_oe), 0);
        if (v.is_rd) chk($sformatf("v%0d_rx_data", idx), int'(rx_data), int'(v.exp_rx));
        else         chk($sformatf("v%0d_ack_rcvd", idx), int'(ack_rcvd), int'(v.exp_ackr));
        step();
        chk($sformatf("v%0d_done_pulse", idx), int'(byte_done), 0);
        slave_low = 1'b0;
        step(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA6, 1'b1, 8'h59, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'hA6, 1'b0, 8'h59, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h0F, 1'b1, 8'hF0, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1};

        rst_n = 1'b0;
        scl = 1'b1;
        slave_low = 1'b0;
        cmd_valid = 1'b0;
        cmd = 2'b00;
        tx_data = 8'h00;
        mst_ack = 1'b0;

        step(2);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_ack_rcvd", int'(ack_rcvd), 0);
        chk("rst_pulses", int'({byte_done, stop_done, cmd_err}), 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", int'(cmd_ready), 1);

        // WRITE, READ, STOP are illegal from IDLE
        for (int c = 1; c < 4; c++) begin
            issue(2'(c));
            chk($sformatf("idle_err_c%0d", c), int'(cmd_err), 1);
            chk($sformatf("idle_stay_c%0d", c), int'(busy), 0);
            step();
            chk($sformatf("idle_err_pulse_c%0d", c), int'(cmd_err), 0);
        end

        start_cond();
        issue(2'b00);
        chk("hold_start_err", int'(cmd_err), 1);
        chk("hold_start_busy", int'(busy), 1);
        chk("hold_start_oe", int'(sda_oe), 1);
        step();
        chk("hold_start_pulse", int'(cmd_err), 0);

        for (int v = 0; v < 5; v++) run_byte(vecs[v], v);

        // STOP with STOP_SETUP = 2
        issue(2'b11);
        chk("stop_drive_low", int'(sda_oe), 1);
        step(2);
        scl = 1'b1;
        step();
        chk("stop_rise_oe", int'(sda_oe), 1);
        step();
        chk("stop_wait_oe", int'(sda_oe), 1);
        chk("stop_wait_done", int'(stop_done), 0);
        step();
        chk("stop_release", int'(sda_oe), 0);
        chk("stop_done", int'(stop_done), 1);
        chk("stop_idle", int'(busy), 0);
        step();
        chk("stop_done_pulse", int'(stop_done), 0);
        step(2);

        // SCL fault during STOP_WAIT
        start_cond();
        issue(2'b11);
        step(2);
        scl = 1'b1;
        step();
        scl = 1'b0;
        step();
        chk("fault_err", int'(cmd_err), 1);
        chk("fault_release", int'(sda_oe), 0);
        chk("fault_idle", int'(busy), 0);
        chk("fault_no_stop_done", int'(stop_done), 0);
        step();
        chk("fault_err_pulse", int'(cmd_err), 0);
        scl = 1'b1;
        step(3);

        // Command held in HOLD while SCL is high, then reset mid-WRITE at bit 3
        start_cond();
        scl = 1'b1;
        step(2);
        tx_data = 8'h80;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        chk("held_not_ready", int'(cmd_ready), 0);
        step();
        chk("held_oe", int'(sda_oe), 1);
        scl = 1'b0;
        step();
        chk("held_oe_fall", int'(sda_oe), 1);
        chk("held_ready_low_scl", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        chk("held_accepted_oe", int'(sda_oe), 0);
        for (int i = 0; i < 4; i++) scl_pulse();
        chk("bit3_oe", int'(sda_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", int'(sda_oe), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
